// File: rtl/prim_alert_rx_pinger.sv
// prim_alert_rx_pinger: receiving end of the differential alert protocol.
// Decodes the alert_p/n pair (tolerating short p==n skew windows), runs the
// four-phase ack handshake, issues level-toggle pings and classifies each
// handshake as an alert or a ping response.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   ping_req_i          request a ping (ignored while one is pending)
//   ping_ok_o           pulse: handshake answered a pending ping
//   ping_timeout_o      pulse: pending ping got no answer in PingTimeout cycles
//   alert_o             pulse: handshake started with no ping pending
//   integ_fail_o        level: alert pair equal for more than SkewTol cycles
//   busy_o              ping pending or handshake in progress
//   alert_pi/alert_ni   differential alert input (already synchronised)
//   ack_po/ack_no       differential ack output
//   ping_po/ping_no     differential ping output
module prim_alert_rx_pinger #(
  parameter int unsigned PingTimeout = 200,
  parameter int unsigned TimerW      = 8,
  parameter int unsigned SkewTol     = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ping_req_i,
  output logic ping_ok_o,
  output logic ping_timeout_o,
  output logic alert_o,
  output logic integ_fail_o,
  output logic busy_o,
  input  logic alert_pi,
  input  logic alert_ni,
  output logic ack_po,
  output logic ack_no,
  output logic ping_po,
  output logic ping_no
);

  localparam int unsigned CntW = 3;

  typedef enum logic [1:0] {
    Idle   = 2'd0,
    HsWait = 2'd1,
    Pause0 = 2'd2,
    Pause1 = 2'd3
  } state_e;

  state_e            r_state;
  logic              r_level;
  logic [CntW-1:0]   r_sig_cnt;
  logic              r_integ_fail;
  logic              r_ack;
  logic              r_ping;
  logic              r_pending;
  logic [TimerW-1:0] r_timer;
  logic              r_ping_ok;
  logic              r_timeout;
  logic              r_alert;

  logic              w_diff;
  logic              w_level_d;
  logic [CntW-1:0]   w_sig_cnt_d;
  logic              w_fail_d;
  logic              w_block;
  logic              w_hs_start;
  logic              w_timer_hit;

  // Differential decoder: a valid (p!=n) pair updates the level, an equal pair
  // holds it and counts how long the pair has been ambiguous.
  assign w_diff      = alert_pi ^ alert_ni;
  assign w_level_d   = w_diff ? alert_pi : r_level;
  assign w_sig_cnt_d = w_diff ? '0
                     : ((r_sig_cnt == {CntW{1'b1}}) ? r_sig_cnt : r_sig_cnt + CntW'(1));
  assign w_fail_d    = (w_sig_cnt_d > CntW'(SkewTol));

  // While the pair is (or has just been) corrupt the handshake FSM is parked in
  // Idle, so the stale held level cannot start a spurious handshake.
  assign w_block     = w_fail_d | r_integ_fail;
  assign w_hs_start  = !w_block && (r_state == Idle) && r_level;
  assign w_timer_hit = (r_timer == TimerW'(PingTimeout - 1));

  // Decoder, handshake FSM and ping tracker.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= Idle;
      r_level      <= 1'b0;
      r_sig_cnt    <= '0;
      r_integ_fail <= 1'b0;
      r_ack        <= 1'b0;
      r_ping       <= 1'b0;
      r_pending    <= 1'b0;
      r_timer      <= '0;
      r_ping_ok    <= 1'b0;
      r_timeout    <= 1'b0;
      r_alert      <= 1'b0;
    end else begin
      r_level      <= w_level_d;
      r_sig_cnt    <= w_sig_cnt_d;
      r_integ_fail <= w_fail_d;
      r_ping_ok    <= 1'b0;
      r_timeout    <= 1'b0;
      r_alert      <= 1'b0;

      if (w_block) begin
        r_state <= Idle;
        r_ack   <= 1'b0;
      end else begin
        case (r_state)
          Idle: begin
            if (r_level) begin
              r_state <= HsWait;
              r_ack   <= 1'b1;
            end
          end
          HsWait: begin
            r_ack <= 1'b1;
            if (!r_level) begin
              r_state <= Pause0;
              r_ack   <= 1'b0;
            end
          end
          Pause0: begin
            r_state <= Pause1;
            r_ack   <= 1'b0;
          end
          Pause1: begin
            r_state <= Idle;
            r_ack   <= 1'b0;
          end
          default: begin
            r_state <= Idle;
            r_ack   <= 1'b0;
          end
        endcase
      end

      // Classify a handshake start; it takes priority over a same-cycle timeout.
      if (w_hs_start) begin
        if (r_pending) begin
          r_ping_ok <= 1'b1;
          r_pending <= 1'b0;
        end else begin
          r_alert <= 1'b1;
        end
      end else if (r_pending) begin
        if (w_timer_hit) begin
          r_timeout <= 1'b1;
          r_pending <= 1'b0;
        end else begin
          r_timer <= r_timer + TimerW'(1);
        end
      end

      // New ping only when nothing is pending at the start of this cycle.
      if (!r_pending && ping_req_i) begin
        r_ping    <= ~r_ping;
        r_pending <= 1'b1;
        r_timer   <= '0;
      end
    end
  end

  assign ping_ok_o      = r_ping_ok;
  assign ping_timeout_o = r_timeout;
  assign alert_o        = r_alert;
  assign integ_fail_o   = r_integ_fail;
  assign busy_o         = r_pending | (r_state != Idle);
  assign ack_po         = r_ack;
  assign ack_no         = ~r_ack;
  assign ping_po        = r_ping;
  assign ping_no        = ~r_ping;

endmodule

// File: tb/tb_prim_alert_rx_pinger.sv
// Directed testbench for prim_alert_rx_pinger (default parameters).
module tb_prim_alert_rx_pinger;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ping_req, alert_p, alert_n;
  logic ping_ok, ping_timeout, alert, integ_fail, busy;
  logic ack_p, ack_n, ping_p, ping_n;

  int n_tests = 0;
  int n_fail  = 0;

  prim_alert_rx_pinger dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ping_req_i     (ping_req),
    .ping_ok_o      (ping_ok),
    .ping_timeout_o (ping_timeout),
    .alert_o        (alert),
    .integ_fail_o   (integ_fail),
    .busy_o         (busy),
    .alert_pi       (alert_p),
    .alert_ni       (alert_n),
    .ack_po         (ack_p),
    .ack_no         (ack_n),
    .ping_po        (ping_p),
    .ping_no        (ping_n)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ping_req = 1'b0; alert_p = 1'b0; alert_n = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic release_alert();
    alert_p = 1'b0; alert_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_reset();
    logic [8:0] v;
    do_reset();
    v = {ack_p, ack_n, ping_p, ping_n, alert, ping_ok, ping_timeout, integ_fail, busy};
    n_tests++;
    if (v !== 9'b010100000) begin
      n_fail++; $display("FAIL reset_state: got %b exp %b", v, 9'b010100000);
    end
  endtask

  task automatic test_alert();
    logic [3:0] v;
    do_reset();
    alert_p = 1'b1; alert_n = 1'b0;
    step();
    v = {ack_p, ack_n, alert, busy};
    n_tests++;
    if (v !== 4'b0100) begin n_fail++; $display("FAIL alert_t1: got %b exp 0100", v); end
    step();
    v = {ack_p, ack_n, alert, busy};
    n_tests++;
    if (v !== 4'b1011) begin n_fail++; $display("FAIL alert_t2: got %b exp 1011", v); end
    step();
    v = {ack_p, ack_n, alert, busy};
    n_tests++;
    if (v !== 4'b1001) begin n_fail++; $display("FAIL alert_hold: got %b exp 1001", v); end
    alert_p = 1'b0; alert_n = 1'b1;
    step();
    n_tests++;
    if (ack_p !== 1'b1) begin n_fail++; $display("FAIL alert_ack_late: got %b exp 1", ack_p); end
    step();
    v = {ack_p, ack_n, alert, busy};
    n_tests++;
    if (v !== 4'b0101) begin n_fail++; $display("FAIL alert_ack_fall: got %b exp 0101", v); end
    step();
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL alert_pause1_busy: got %b exp 1", busy); end
    step();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL alert_idle_busy: got %b exp 0", busy); end
  endtask

  task automatic test_ping_ok();
    logic [2:0] v;
    do_reset();
    ping_req = 1'b1;
    step();
    ping_req = 1'b0;
    v = {ping_p, ping_n, busy};
    n_tests++;
    if (v !== 3'b101) begin n_fail++; $display("FAIL ping_issue: got %b exp 101", v); end
    step(); step();
    alert_p = 1'b1; alert_n = 1'b0;
    step(); step();
    v = {ping_ok, alert, ack_p};
    n_tests++;
    if (v !== 3'b101) begin n_fail++; $display("FAIL ping_ok_pulse: got %b exp 101", v); end
    step();
    v = {ping_ok, alert, ack_p};
    n_tests++;
    if (v !== 3'b001) begin n_fail++; $display("FAIL ping_ok_once: got %b exp 001", v); end
    release_alert();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ping_ok_busy: got %b exp 0", busy); end
  endtask

  task automatic test_timeout();
    int n_to = 0;
    int first = -1;
    logic busy_at = 1'b1;
    do_reset();
    ping_req = 1'b1;
    step();
    ping_req = 1'b0;
    for (int k = 1; k <= 210; k++) begin
      step();
      if (ping_timeout === 1'b1) begin
        n_to++;
        if (first < 0) begin first = k; busy_at = busy; end
      end
    end
    n_tests++;
    if (n_to !== 1) begin n_fail++; $display("FAIL timeout_count: got %0d exp 1", n_to); end
    n_tests++;
    if (first !== 200) begin n_fail++; $display("FAIL timeout_cycle: got %0d exp 200", first); end
    n_tests++;
    if (busy_at !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b exp 0", busy_at); end
    ping_req = 1'b1;
    step();
    ping_req = 1'b0;
    n_tests++;
    if ({ping_p, ping_n, busy} !== 3'b011) begin
      n_fail++; $display("FAIL timeout_reping: got %b exp 011", {ping_p, ping_n, busy});
    end
  endtask

  task automatic test_skew();
    logic [2:0] v;
    do_reset();
    alert_p = 1'b1; alert_n = 1'b1;
    step();
    alert_p = 1'b1; alert_n = 1'b0;
    step();
    n_tests++;
    if (integ_fail !== 1'b0) begin n_fail++; $display("FAIL skew_short_integ: got %b exp 0", integ_fail); end
    step();
    v = {ack_p, alert, integ_fail};
    n_tests++;
    if (v !== 3'b110) begin n_fail++; $display("FAIL skew_short_hs: got %b exp 110", v); end
    alert_p = 1'b1; alert_n = 1'b1;
    step();
    v = {ack_p, busy, integ_fail};
    n_tests++;
    if (v !== 3'b110) begin n_fail++; $display("FAIL skew_long_c1: got %b exp 110", v); end
    step();
    v = {ack_p, busy, integ_fail};
    n_tests++;
    if (v !== 3'b001) begin n_fail++; $display("FAIL skew_long_c2: got %b exp 001", v); end
    step();
    n_tests++;
    if (integ_fail !== 1'b1) begin n_fail++; $display("FAIL skew_long_c3: got %b exp 1", integ_fail); end
    alert_p = 1'b0; alert_n = 1'b1;
    step();
    n_tests++;
    if (integ_fail !== 1'b0) begin n_fail++; $display("FAIL skew_clear: got %b exp 0", integ_fail); end
  endtask

  task automatic test_edge_ping();
    int n_to = 0;
    do_reset();
    ping_req = 1'b1;
    step();
    for (int k = 1; k <= 198; k++) begin
      ping_req = (k >= 10 && k <= 12) ? 1'b1 : 1'b0;
      step();
    end
    ping_req = 1'b0;
    n_tests++;
    if (ping_p !== 1'b1) begin n_fail++; $display("FAIL edge_no_retoggle: got %b exp 1", ping_p); end
    alert_p = 1'b1; alert_n = 1'b0;
    step();
    n_tests++;
    if ({ping_ok, ping_timeout, busy} !== 3'b001) begin
      n_fail++; $display("FAIL edge_before: got %b exp 001", {ping_ok, ping_timeout, busy});
    end
    step();
    n_tests++;
    if ({ping_ok, ping_timeout, alert} !== 3'b100) begin
      n_fail++; $display("FAIL edge_ok_wins: got %b exp 100", {ping_ok, ping_timeout, alert});
    end
    alert_p = 1'b0; alert_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ping_timeout === 1'b1) n_to++;
    end
    n_tests++;
    if ({n_to == 0, busy, ping_p} !== 3'b101) begin
      n_fail++; $display("FAIL edge_after: got to=%0d busy=%b ping=%b exp to=0 busy=0 ping=1", n_to, busy, ping_p);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    do_reset();
    ping_req = 1'b1;
    step();
    ping_req = 1'b0;
    alert_p = 1'b1; alert_n = 1'b0;
    step(); step();
    n_tests++;
    if ({ack_p, ping_p} !== 2'b11) begin n_fail++; $display("FAIL mid_pre: got %b exp 11", {ack_p, ping_p}); end
    rst = 1'b1;
    step();
    v = {ack_p, ack_n, ping_p, busy, ping_ok, alert, ping_timeout, integ_fail};
    n_tests++;
    if (v !== 8'b01000000) begin n_fail++; $display("FAIL mid_reset: got %b exp 01000000", v); end
    rst = 1'b0;
    alert_p = 1'b0; alert_n = 1'b1;
    step();
    v = {ack_p, ack_n, ping_p, busy, ping_ok, alert, ping_timeout, integ_fail};
    n_tests++;
    if (v !== 8'b01000000) begin n_fail++; $display("FAIL mid_after: got %b exp 01000000", v); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alert();
    test_ping_ok();
    test_timeout();
    test_skew();
    test_edge_ping();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
